cdb_rr_arbiter: RTL and testbench
=================================

Name: cdb_rr_arbiter

Overview:
- Parametrised common-data-bus arbiter for the Tomasulo core. Generalises the fixed 4-source, fixed-priority CDB/CDBHelper pair to NUM_UNITS sources.
- Each functional unit pushes completed results (data + reservation-station label) into a private result buffer.
- A round-robin arbiter drains one buffered result per cycle onto a registered broadcast bus (BCEN/BClabel/BCdata) consumed by RegFile, reservation stations and operand queues.
- Buffering removes the requirement that a unit hold its result until accepted.

Parameters:
NUM_UNITS, 4, number of result sources (>=2); unit i at slice i of every packed vector
DATA_W, 32, result data width
LABEL_W, 4, reservation-station label width; label value 0 means "no producer"
BUF_DEPTH, 2, entries per source buffer (power of two, >=1)

Ports:
clk  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
in_valid  in  NUM_UNITS  unit i offers a result this cycle
in_ready  out  NUM_UNITS  unit i buffer can accept; push occurs when in_valid[i] & in_ready[i]
in_data  in  NUM_UNITS*DATA_W  unit i data at [i*DATA_W +: DATA_W]
in_label  in  NUM_UNITS*LABEL_W  unit i label at [i*LABEL_W +: LABEL_W]
BCEN  out  1  broadcast valid, registered
BClabel  out  LABEL_W  broadcast label, registered
BCdata  out  DATA_W  broadcast data, registered
BCgrant  out  NUM_UNITS  one-hot source of the current broadcast, registered
drop_err  out  1  sticky: a label-0 push was discarded

Behaviour:
- Reset (RST high at a clock edge): all buffers emptied, RR pointer = 0, BCEN = 0, BClabel = 0, BCdata = 0, BCgrant = 0, drop_err = 0.
  - Reset has priority over every push/pop in that cycle.
  - Buffered results are discarded.
  - in_ready is low during the reset cycle and high from the next cycle.
- Buffers: one FIFO per unit with BUF_DEPTH entries. Count range 0..BUF_DEPTH; read/write pointers wrap modulo BUF_DEPTH.
  - in_ready[i] = (count_i < BUF_DEPTH), based on the registered count only. It does not consider a same-cycle pop, so a full buffer rejects a push even while it is being drained.
  - Same-cycle push and pop on a non-full, non-empty buffer: both take effect, count unchanged.
  - Push to an empty buffer: the entry is eligible for arbitration in the next cycle. There is no bypass.
- Label-0 push (in_valid & in_ready & label==0): not stored, drop_err set to 1 and held until reset.
- Arbitration (combinational on registered state, each cycle):
  - Candidates are the units with count_i > 0.
  - Grant g = first candidate at index >= ptr, searching upward and wrapping to 0.
  - If a grant exists: pop the head of buffer g; at the next edge BCEN=1, BClabel/BCdata = head entry, BCgrant = one-hot(g); ptr <= (g+1) mod NUM_UNITS.
  - If no candidate: BCEN=0 next cycle, BCgrant=0, ptr unchanged. BClabel/BCdata hold their last values; consumers ignore them while BCEN=0.
- Latency: push accepted at edge t -> earliest broadcast visible after edge t+1, one cycle later.
- Throughput: one broadcast per cycle.
- Starvation bound: a non-empty buffer is granted within NUM_UNITS cycles.
- Ordering: per-unit FIFO order preserved. No ordering between units.
- No broadcast ever carries label 0.

Test Plan:
- Reset then idle: after RST, BCEN=0, BCgrant=0, in_ready=4'b1111, drop_err=0 for 10 cycles with no pushes.
- Single push: unit 2 pushes label 5, data 0xDEADBEEF at edge t -> after edge t+1 BCEN=1, BClabel=5, BCdata=0xDEADBEEF, BCgrant=4'b0100; BCEN=0 after edge t+2.
- All four units push in the same cycle (labels 1..4), ptr=0 -> broadcasts over 4 consecutive cycles with labels 1,2,3,4 and BCgrant 0001,0010,0100,1000; then ptr=0.
- Fairness: unit 0 pushes every cycle and unit 3 pushes once -> unit 3's result broadcast within 4 cycles of becoming eligible; grants alternate 0,3,0.
- Backpressure: unit 1 pushes 3 results in consecutive cycles while unit 0's buffer keeps winning (BUF_DEPTH=2) -> in_ready[1] drops after 2 pushes, third push not accepted; unit must retry; all accepted results broadcast in push order.
- Label 0 and reset mid-operation: unit 0 pushes label 0 -> no broadcast, drop_err=1. Fill all buffers, assert RST for one cycle -> next cycle BCEN=0, drop_err=0, no stale result ever broadcast.

Source files
------------

// File: rtl/cdb_rr_arbiter.sv
// =============================================================================
// Module  : cdb_rr_arbiter
// Brief   : Buffers one result FIFO per functional unit and drains them
//           round-robin onto a registered common-data-bus broadcast.
// Revision: 1.0
// =============================================================================
`default_nettype none

module cdb_rr_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int LABEL_W   = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           RST,
    input  logic [NUM_UNITS-1:0]           in_valid,
    output logic [NUM_UNITS-1:0]           in_ready,
    input  logic [NUM_UNITS*DATA_W-1:0]    in_data,
    input  logic [NUM_UNITS*LABEL_W-1:0]   in_label,
    output logic                           BCEN,
    output logic [LABEL_W-1:0]             BClabel,
    output logic [DATA_W-1:0]              BCdata,
    output logic [NUM_UNITS-1:0]           BCgrant,
    output logic                           drop_err
);

    localparam int ENTRY_W = LABEL_W + DATA_W;
    localparam int IDX_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam int UNIT_W  = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]              w_nonempty;
    logic [NUM_UNITS-1:0]              w_pop;
    logic [NUM_UNITS-1:0]              w_drop;
    logic [NUM_UNITS-1:0][ENTRY_W-1:0] w_head;

    logic                              w_grant_valid;
    logic [UNIT_W-1:0]                 w_grant_idx;

    logic [UNIT_W-1:0]                 rr_ptr_q;
    logic                              bcen_q;
    logic [LABEL_W-1:0]                bclabel_q;
    logic [DATA_W-1:0]                 bcdata_q;
    logic [NUM_UNITS-1:0]              bcgrant_q;
    logic                              drop_err_q;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_buf
        logic [CNT_W-1:0]   count_q, count_d;
        logic [IDX_W-1:0]   rd_q, wr_q;
        logic [ENTRY_W-1:0] mem_q [BUF_DEPTH];
        logic               w_accept;
        logic               w_store;

        // Readiness ignores a same-cycle pop so a full buffer never accepts.
        assign in_ready[i]   = !RST && (count_q < CNT_W'(BUF_DEPTH));
        assign w_accept      = in_valid[i] && in_ready[i];
        assign w_store       = w_accept && (in_label[i*LABEL_W +: LABEL_W] != '0);
        assign w_drop[i]     = w_accept && (in_label[i*LABEL_W +: LABEL_W] == '0);
        assign w_nonempty[i] = (count_q != '0);
        assign w_head[i]     = mem_q[rd_q];

        always_comb begin
            count_d = count_q;
            case ({w_store, w_pop[i]})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (RST) begin
                count_q <= '0;
                rd_q    <= '0;
                wr_q    <= '0;
            end else begin
                count_q <= count_d;
                if (w_store)  wr_q <= next_idx(wr_q);
                if (w_pop[i]) rd_q <= next_idx(rd_q);
            end
        end

        always_ff @(posedge clk) begin
            if (w_store) mem_q[wr_q] <= {in_label[i*LABEL_W +: LABEL_W], in_data[i*DATA_W +: DATA_W]};
        end
    end

    // Scan from the highest offset down so the lowest offset from the pointer wins.
    always_comb begin
        int cand;
        cand          = 0;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_UNITS) cand = cand - NUM_UNITS;
            if (w_nonempty[UNIT_W'(cand)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = UNIT_W'(cand);
            end
        end
    end

    assign w_pop = w_grant_valid ? (NUM_UNITS'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            rr_ptr_q   <= '0;
            bcen_q     <= 1'b0;
            bclabel_q  <= '0;
            bcdata_q   <= '0;
            bcgrant_q  <= '0;
            drop_err_q <= 1'b0;
        end else begin
            bcen_q    <= w_grant_valid;
            bcgrant_q <= w_pop;
            if (w_grant_valid) begin
                bclabel_q <= w_head[w_grant_idx][ENTRY_W-1 -: LABEL_W];
                bcdata_q  <= w_head[w_grant_idx][DATA_W-1:0];
                rr_ptr_q  <= (w_grant_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (|w_drop) drop_err_q <= 1'b1;
        end
    end

    assign BCEN     = bcen_q;
    assign BClabel  = bclabel_q;
    assign BCdata   = bcdata_q;
    assign BCgrant  = bcgrant_q;
    assign drop_err = drop_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_rr_arbiter.sv
// =============================================================================
// Module  : tb_cdb_rr_arbiter
// Brief   : Directed self-checking bench for cdb_rr_arbiter (4 units, depth 2).
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_cdb_rr_arbiter;

    logic         clk;
    logic         RST;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_label;
    logic         BCEN;
    logic [3:0]   BClabel;
    logic [31:0]  BCdata;
    logic [3:0]   BCgrant;
    logic         drop_err;

    int errors = 0;
    int checks = 0;

    cdb_rr_arbiter #(
        .NUM_UNITS(4),
        .DATA_W   (32),
        .LABEL_W  (4),
        .BUF_DEPTH(2)
    ) dut (
        .clk     (clk),
        .RST     (RST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_label(in_label),
        .BCEN    (BCEN),
        .BClabel (BClabel),
        .BCdata  (BCdata),
        .BCgrant (BCgrant),
        .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        in_valid = '0;
        in_data  = '0;
        in_label = '0;
    endtask

    task automatic push(input int u, input logic [3:0] lab, input logic [31:0] d);
        in_valid[u]         = 1'b1;
        in_label[u*4 +: 4]  = lab;
        in_data[u*32 +: 32] = d;
    endtask

    task automatic check_bc(input string tag, input logic [3:0] lab, input logic [31:0] d,
                            input logic [3:0] g);
        check({tag, ".en"},    64'(BCEN),    64'd1);
        check({tag, ".label"}, 64'(BClabel), 64'(lab));
        check({tag, ".data"},  64'(BCdata),  64'(d));
        check({tag, ".grant"}, 64'(BCgrant), 64'(g));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".en"},    64'(BCEN),    64'd0);
        check({tag, ".grant"}, 64'(BCgrant), 64'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        clear_in();

        // Reset and idle
        tick();
        tick();
        check("rst.ready_low", 64'(in_ready), 64'h0);
        RST = 1'b0;
        check("rst.en",    64'(BCEN),     64'd0);
        check("rst.grant", 64'(BCgrant),  64'd0);
        check("rst.label", 64'(BClabel),  64'd0);
        check("rst.data",  64'(BCdata),   64'd0);
        check("rst.drop",  64'(drop_err), 64'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle("idle");
            check("idle.ready", 64'(in_ready), 64'hF);
            check("idle.drop",  64'(drop_err), 64'd0);
        end

        // Single push from unit 2
        push(2, 4'd5, 32'hDEADBEEF);
        tick();
        clear_in();
        check("single.nobypass", 64'(BCEN), 64'd0);
        tick();
        check_bc("single", 4'd5, 32'hDEADBEEF, 4'b0100);
        tick();
        check_idle("single.after");

        // All four units at once from pointer 0
        do_reset();
        for (int u = 0; u < 4; u++) push(u, 4'(u + 1), 32'h100 + 32'(u));
        tick();
        clear_in();
        tick();
        check_bc("all0", 4'd1, 32'h100, 4'b0001);
        tick();
        check_bc("all1", 4'd2, 32'h101, 4'b0010);
        tick();
        check_bc("all2", 4'd3, 32'h102, 4'b0100);
        tick();
        check_bc("all3", 4'd4, 32'h103, 4'b1000);
        tick();
        check_idle("all.after");

        // Fairness: unit 0 streams, unit 3 pushes once; pointer back at 0
        push(0, 4'd6, 32'hA6);
        push(3, 4'd7, 32'hB7);
        tick();
        clear_in();
        push(0, 4'd8, 32'hA8);
        tick();
        check_bc("fair0", 4'd6, 32'hA6, 4'b0001);
        clear_in();
        push(0, 4'd9, 32'hA9);
        tick();
        check_bc("fair1", 4'd7, 32'hB7, 4'b1000);
        clear_in();
        tick();
        check_bc("fair2", 4'd8, 32'hA8, 4'b0001);
        tick();
        check_bc("fair3", 4'd9, 32'hA9, 4'b0001);
        tick();
        check_idle("fair.after");

        // Backpressure on unit 1 while unit 0 competes
        do_reset();
        push(0, 4'd1, 32'hA1);
        push(1, 4'd2, 32'hB1);
        tick();
        check("bp.ready1", 64'(in_ready), 64'hF);
        clear_in();
        push(0, 4'd3, 32'hA2);
        push(1, 4'd4, 32'hB2);
        tick();
        check_bc("bp0", 4'd1, 32'hA1, 4'b0001);
        check("bp.ready2", 64'(in_ready), 64'b1101);
        clear_in();
        push(0, 4'd5, 32'hA3);
        push(1, 4'd6, 32'hB3);
        tick();
        check_bc("bp1", 4'd2, 32'hB1, 4'b0010);
        check("bp.ready3", 64'(in_ready), 64'b1110);
        clear_in();
        push(1, 4'd6, 32'hB3);
        tick();
        clear_in();
        check_bc("bp2", 4'd3, 32'hA2, 4'b0001);
        tick();
        check_bc("bp3", 4'd4, 32'hB2, 4'b0010);
        tick();
        check_bc("bp4", 4'd5, 32'hA3, 4'b0001);
        tick();
        check_bc("bp5", 4'd6, 32'hB3, 4'b0010);
        tick();
        check_idle("bp.after");

        // Label 0 is dropped and flagged
        push(0, 4'd0, 32'h55);
        tick();
        clear_in();
        check("drop.flag", 64'(drop_err), 64'd1);
        check("drop.nobc", 64'(BCEN),     64'd0);
        tick();
        check("drop.nobc2",  64'(BCEN),     64'd0);
        check("drop.sticky", 64'(drop_err), 64'd1);

        // Fill every buffer, then reset with pushes still offered
        for (int u = 0; u < 4; u++) push(u, 4'(u + 1), 32'hC0 + 32'(u));
        tick();
        tick();
        check("fill.bc", 64'(BCEN), 64'd1);
        RST = 1'b1;
        tick();
        check("mrst.ready_low", 64'(in_ready), 64'h0);
        RST = 1'b0;
        clear_in();
        check_idle("mrst");
        check("mrst.drop",  64'(drop_err), 64'd0);
        check("mrst.label", 64'(BClabel),  64'd0);
        check("mrst.data",  64'(BCdata),   64'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_idle("mrst.stale");
            check("mrst.ready", 64'(in_ready), 64'hF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
